// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller and the datapath muxes it drives.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTYPE  = 4'd6,
        S_SHIFT  = 4'd7,
        S_ALUWB  = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_LUIEX  = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;

    localparam logic [2:0] SRCA_PC   = 3'd0;
    localparam logic [2:0] SRCA_REGA = 3'd1;
    localparam logic [2:0] SRCA_ZERO = 3'd2;
    localparam logic [2:0] SRCA_SZSE = 3'd3;
    localparam logic [2:0] SRCA_REGB = 3'd4;

    localparam logic [2:0] SRCB_REGB   = 3'd0;
    localparam logic [2:0] SRCB_FOUR   = 3'd1;
    localparam logic [2:0] SRCB_SZSE   = 3'd2;
    localparam logic [2:0] SRCB_SZSE4  = 3'd3;
    localparam logic [2:0] SRCB_SHAMT  = 3'd4;
    localparam logic [2:0] SRCB_SIXTEEN = 3'd5;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;
    localparam logic [2:0] ALU_SLL   = 3'd6;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic [2:0] alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // Moore strobes for a state; anything not named stays zero.
    function automatic ctrl_t moore_ctrl(state_t s, logic [2:0] imm_op, logic bne);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            S_DECODE:  c.alu_src_b = SRCB_SZSE4;
            S_MEMADR: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_SZSE;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_RTYPE: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_op    = ALU_FUNCT;
            end
            S_SHIFT: begin
                c.alu_src_a = SRCA_REGB;
                c.alu_src_b = SRCB_SHAMT;
                c.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_IMMEX: begin
                c.alu_src_a = SRCA_REGA;
                c.alu_src_b = SRCB_SZSE;
                c.alu_op    = imm_op;
            end
            S_LUIEX: begin
                c.alu_src_a = SRCA_SZSE;
                c.alu_src_b = SRCB_SIXTEEN;
                c.alu_op    = ALU_SLL;
            end
            S_IMMWB:   c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a     = SRCA_REGA;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCS_ALUOUT;
                c.branch_ne     = bne;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCS_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Opcode-only decode: ALU operation for immediate instructions and immediate sign-extension.
module mc_alu_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] imm_op,
    output logic       sign_ext
);

    always_comb begin
        imm_op = ALU_ADD;
        case (opcode)
            OP_SLTI: imm_op = ALU_SLT;
            OP_ANDI: imm_op = ALU_AND;
            OP_ORI:  imm_op = ALU_OR;
            default: imm_op = ALU_ADD;
        endcase
    end

    // Logical immediates are zero-extended.
    assign sign_ext = !((opcode == OP_ANDI) || (opcode == OP_ORI));

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control FSM: registered Moore strobes, fetch-complete strobes from MemReady.
//   state  | meaning
//   FETCH  | read instruction, PC+4; wait MemReady
//   DECODE | dispatch on opcode, precompute branch target
//   MEMADR | lw/sw effective address
//   MEMRD  | data read; wait MemReady
//   MEMWB  | load result to rt
//   MEMWR  | data write; wait MemReady
//   RTYPE  | register ALU op
//   SHIFT  | shift by shamt
//   ALUWB  | ALU result to rd
//   IMMEX  | immediate ALU op
//   IMMWB  | immediate/lui result to rt
//   BRANCH | beq/bne compare, conditional PC write
//   JUMP   | PC <- jump target
//   LUIEX  | immediate << 16
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       SignExt,
    output logic [2:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       Illegal
);

    state_t     state;
    state_t     nxt;
    ctrl_t      ctl;
    logic [2:0] imm_op;
    logic       illegal_op;
    logic       fetch_done;

    mc_alu_decode u_alu_decode (
        .opcode   (Opcode),
        .imm_op   (imm_op),
        .sign_ext (SignExt)
    );

    always_comb begin
        nxt        = S_FETCH;
        illegal_op = 1'b0;
        case (state)
            S_FETCH:  nxt = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_RTYPE: nxt = ((Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA))
                                    ? S_SHIFT : S_RTYPE;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: nxt = S_IMMEX;
                    OP_LUI:         nxt = S_LUIEX;
                    OP_BEQ, OP_BNE: nxt = S_BRANCH;
                    OP_J:           nxt = S_JUMP;
                    default: begin
                        nxt        = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = MemReady ? S_FETCH : S_MEMWR;
            S_RTYPE, S_SHIFT: nxt = S_ALUWB;
            S_IMMEX, S_LUIEX: nxt = S_IMMWB;
            default:  nxt = S_FETCH;
        endcase
    end

    // Strobes are computed for the state being entered so they come straight off flops.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_FETCH;
            ctl   <= moore_ctrl(S_FETCH, ALU_ADD, 1'b0);
        end else begin
            state <= nxt;
            ctl   <= moore_ctrl(nxt, imm_op, Opcode == OP_BNE);
        end
    end

    assign fetch_done  = (state == S_FETCH) && MemReady;

    assign PCWrite     = ctl.pc_write | fetch_done;
    assign IRWrite     = fetch_done;
    assign PCWriteCond = ctl.pc_write_cond;
    assign BranchNE    = ctl.branch_ne;
    assign IorD        = ctl.iord;
    assign MemRead     = ctl.mem_read;
    assign MemWrite    = ctl.mem_write;
    assign MemtoReg    = ctl.mem_to_reg;
    assign RegDst      = ctl.reg_dst;
    assign RegWrite    = ctl.reg_write;
    assign ALUSrcA     = ctl.alu_src_a;
    assign ALUSrcB     = ctl.alu_src_b;
    assign ALUOp       = ctl.alu_op;
    assign PCSource    = ctl.pc_source;
    assign State       = state;
    assign Illegal     = illegal_op;

endmodule
